// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/half/word loads with extension, SB/SH via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of masking the low bits.
module load_store_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    output logic        o_ready,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmw, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        err_q, err_d;

    logic        illegal, misalign;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val, merged;

    always_comb begin
        if (i_we) begin
            illegal = i_funct3[2] || (i_funct3[1:0] == 2'b11);
        end else begin
            illegal = (i_funct3[1:0] == 2'b11) || (i_funct3 == 3'b110);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0])
                || ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Lane selection ignores addr bits below natural alignment, which masks misaligned halves.
    always_comb begin
        byte_sel = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = i_mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h000000, byte_sel};
            3'b101:  load_val = {16'h0000, half_sel};
            default: load_val = i_mem_rdata;
        endcase
    end

    // Store data sits in mem_wdata_q from accept; RMW splices its low lane into the old word.
    always_comb begin
        merged = i_mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = mem_wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = mem_wdata_q[15:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (i_req) begin
                    funct3_d = i_funct3;
                    addr_d   = i_addr;
                    err_d    = illegal || misalign;
                    if (i_we) begin
                        mem_wdata_d = i_wdata;
                    end
                    if (illegal || misalign) begin
                        state_d = StDone;
                    end else if (!i_we) begin
                        state_d = StLoad;
                    end else if (i_funct3[1:0] == 2'b10) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmw;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_val;
                state_d = StDone;
            end
            StRmw: begin
                mem_wdata_d = merged;
                state_d     = StWrite;
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0;
            rdata_q     <= 32'h0;
            mem_wdata_q <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    // Strobes are gated by reset so an op caught mid-flight never writes or completes.
    assign o_ready     = (state_q == StIdle);
    assign o_valid     = (state_q == StDone) && !i_rst;
    assign o_err       = o_valid && err_q;
    assign o_mem_we    = (state_q == StWrite) && !i_rst;
    assign o_mem_addr  = {addr_q[31:2], 2'b00};
    assign o_mem_wdata = mem_wdata_q;
    assign o_rdata     = rdata_q;

endmodule
